spi_master: RTL and testbench

- SPI bus master for the off-chip serial links: drives CS_N, SCK and MOSI, and samples MISO. Mode 0 only (CPOL=0, CPHA=0), MSB first, one word per CS_N assertion.
- Sits between a local byte producer/consumer (valid/ready on transmit, one-cycle strobe on receive) and an external SPI slave.
- SCK is generated from sys_clk by a programmable divider.

---
 rtl/spi_master.sv | 213 +++++++++++++++++++++
 tb/tb_spi_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// SPI bus master, mode 0 (CPOL=0, CPHA=0), MSB first, one word per CS_N frame.
// SCK is derived from sys_clk: each SCK half-period lasts CLK_DIV sys_clk cycles.
//
// Optional feature macro: SPI_MASTER_BURST_EN
//   When defined, a new word offered on the final SCK high cycle is accepted
//   and chained into the same CS_N frame (no HOLD/GAP/SETUP in between).
//
// Ports:
//   sys_clk    in   system clock, all logic on its rising edge
//   rst        in   synchronous active-high reset
//   tx_valid   in   txd_data is valid
//   tx_ready   out  block can accept a word
//   txd_data   in   word to transmit
//   rxd_data   out  last received word, held until the next completion
//   rxd_valid  out  one-cycle strobe, coincident with rxd_data update
//   busy       out  high whenever the FSM is not idle
//   CS_N       out  chip select, active low
//   SCK        out  serial clock, idles low
//   MOSI       out  serial data out
//   MISO       in   serial data in, already synchronous to sys_clk
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] txd_data,
    output logic [DATA_W-1:0] rxd_data,
    output logic              rxd_valid,
    output logic              busy,
    output logic              CS_N,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO
);

    // Largest phase length decides the divider counter width.
    localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_div_cnt;
    logic [CNT_W-1:0]    w_len_m1;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [DATA_W-1:0]   w_tx_next;
    logic                w_phase_last;
    logic                w_last_bit;
    logic                w_accept;

    assign w_tx_next    = r_tx_shift << 1;
    assign w_phase_last = (r_div_cnt == w_len_m1);
    assign w_last_bit   = (r_bit_cnt == BIT_W'(DATA_W - 1));
    assign w_accept     = tx_valid && tx_ready;
    assign busy         = (r_state != S_IDLE);

    // Terminal count of the current phase (length minus one).
    always_comb begin
        w_len_m1 = {CNT_W{1'b0}};
        case (r_state)
            S_SETUP:    w_len_m1 = CNT_W'(CS_SETUP - 1);
            S_LO, S_HI: w_len_m1 = CNT_W'(CLK_DIV - 1);
            S_HOLD:     w_len_m1 = CNT_W'(CS_HOLD - 1);
            S_GAP:      w_len_m1 = CNT_W'(CS_GAP - 1);
            default:    w_len_m1 = {CNT_W{1'b0}};
        endcase
    end

    // Ready: idle, or (burst build) chaining a word on the final SCK high cycle.
    always_comb begin
        tx_ready = 1'b0;
`ifdef SPI_MASTER_BURST_EN
        if (!rst && ((r_state == S_IDLE) ||
                     ((r_state == S_HI) && w_phase_last && w_last_bit && tx_valid))) begin
            tx_ready = 1'b1;
        end else begin
            tx_ready = 1'b0;
        end
`else
        if (!rst && (r_state == S_IDLE)) begin
            tx_ready = 1'b1;
        end else begin
            tx_ready = 1'b0;
        end
`endif
    end

    // Next-state logic for the transfer FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_SETUP;
                else          w_state_nxt = S_IDLE;
            end
            S_SETUP: begin
                if (w_phase_last) w_state_nxt = S_LO;
                else              w_state_nxt = S_SETUP;
            end
            S_LO: begin
                if (w_phase_last) w_state_nxt = S_HI;
                else              w_state_nxt = S_LO;
            end
            S_HI: begin
                // w_accept can only be true here in the burst build.
                if (w_phase_last && w_last_bit) w_state_nxt = w_accept ? S_LO : S_HOLD;
                else if (w_phase_last)          w_state_nxt = S_LO;
                else                            w_state_nxt = S_HI;
            end
            S_HOLD: begin
                if (w_phase_last) w_state_nxt = S_GAP;
                else              w_state_nxt = S_HOLD;
            end
            S_GAP: begin
                if (w_phase_last) w_state_nxt = S_IDLE;
                else              w_state_nxt = S_GAP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Datapath: divider, shift registers and SPI pin registers.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_div_cnt  <= {CNT_W{1'b0}};
            r_bit_cnt  <= {BIT_W{1'b0}};
            r_tx_shift <= {DATA_W{1'b0}};
            r_rx_shift <= {DATA_W{1'b0}};
            rxd_data   <= {DATA_W{1'b0}};
            rxd_valid  <= 1'b0;
            CS_N       <= 1'b1;
            SCK        <= 1'b0;
            MOSI       <= 1'b0;
        end else begin
            rxd_valid <= 1'b0;
            // Divider restarts at every phase boundary and stays cleared in idle.
            if ((r_state == S_IDLE) || w_phase_last) r_div_cnt <= {CNT_W{1'b0}};
            else                                      r_div_cnt <= r_div_cnt + CNT_W'(1);

            if (w_accept) begin
                r_tx_shift <= txd_data;
                MOSI       <= txd_data[DATA_W-1];
                CS_N       <= 1'b0;
                r_bit_cnt  <= {BIT_W{1'b0}};
            end

            case (r_state)
                S_LO: begin
                    // MISO is captured on the same edge SCK rises.
                    if (w_phase_last) begin
                        SCK        <= 1'b1;
                        r_rx_shift <= DATA_W'({r_rx_shift, MISO});
                    end
                end
                S_HI: begin
                    if (w_phase_last) begin
                        SCK <= 1'b0;
                        if (!w_last_bit) begin
                            r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                            r_tx_shift <= w_tx_next;
                            MOSI       <= w_tx_next[DATA_W-1];
                        end
`ifdef SPI_MASTER_BURST_EN
                        else if (w_accept) begin
                            // Chained word: report the finished one right away.
                            rxd_data  <= r_rx_shift;
                            rxd_valid <= 1'b1;
                        end
`endif
                    end
                end
                S_HOLD: begin
                    if (w_phase_last) begin
                        CS_N      <= 1'b1;
                        rxd_data  <= r_rx_shift;
                        rxd_valid <= 1'b1;
                        MOSI      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] txd;
    bit         sel;        // 0: default DUT, 1: fast DUT
    bit         loop_sel;   // 1: MISO = MOSI
    logic       miso_drv;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         rise_cyc = 0;
    int         fall_cyc = 0;
    logic [7:0] exp_q[$];

    logic       rdy_d, rv_d, busy_d, cs_d, sck_d, mosi_d, miso_d;
    logic       rdy_f, rv_f, busy_f, cs_f, sck_f, mosi_f, miso_f;
    logic [7:0] rx_d, rx_f;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign miso_d = loop_sel ? mosi_d : miso_drv;
    assign miso_f = loop_sel ? mosi_f : miso_drv;

    spi_master u_dut (
        .sys_clk(clk), .rst(rst), .tx_valid(tx_valid && !sel), .tx_ready(rdy_d),
        .txd_data(txd), .rxd_data(rx_d), .rxd_valid(rv_d), .busy(busy_d),
        .CS_N(cs_d), .SCK(sck_d), .MOSI(mosi_d), .MISO(miso_d)
    );

    spi_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) u_fast (
        .sys_clk(clk), .rst(rst), .tx_valid(tx_valid && sel), .tx_ready(rdy_f),
        .txd_data(txd), .rxd_data(rx_f), .rxd_valid(rv_f), .busy(busy_f),
        .CS_N(cs_f), .SCK(sck_f), .MOSI(mosi_f), .MISO(miso_f)
    );

    logic       o_rdy, o_rv, o_busy, o_cs, o_sck, o_mosi;
    logic [7:0] o_rx;
    assign o_rdy  = sel ? rdy_f  : rdy_d;
    assign o_rv   = sel ? rv_f   : rv_d;
    assign o_busy = sel ? busy_f : busy_d;
    assign o_cs   = sel ? cs_f   : cs_d;
    assign o_sck  = sel ? sck_f  : sck_d;
    assign o_mosi = sel ? mosi_f : mosi_d;
    assign o_rx   = sel ? rx_f   : rx_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Offer tx_valid and wait (bounded) until the selected DUT is ready.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!o_rdy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(o_rdy), 32'd1);
    endtask

    // One complete word transfer with full frame measurement.
    task automatic xfer(input logic [7:0] word, input logic [7:0] nxt, input bit hold,
                        input bit loop, input logic [7:0] slave, input logic [7:0] exp_rx,
                        input int exp_cs, input int exp_div, input string tag);
        int cs_low = 0, rises = 0, hi_run = 0, lo_run = 0, vcnt = 0;
        bit bad_hi = 0, bad_lo = 0, ready_bad = 0, coinc_bad = 0, prev = 0;
        logic [7:0] mseq = 8'h00;
        logic [7:0] got_rx = 8'h00;
        logic [7:0] exp_v = 8'h00;
        loop_sel = loop;
        miso_drv = slave[7];
        txd      = word;
        tx_valid = 1'b1;
        wait_ready(tag);
        exp_q.push_back(exp_rx);
        @(posedge clk);
        #1;
        fall_cyc = cyc;
        txd      = nxt;
        tx_valid = hold;
        for (int n = 0; n < 600 && vcnt == 0; n++) begin
            @(negedge clk);
            if (!o_cs) cs_low++;
            if (!o_cs && o_rdy) ready_bad = 1;
            if (o_sck && !prev) begin
                rises++;
                mseq = {mseq[6:0], o_mosi};
                if (rises > 1 && lo_run != exp_div) bad_lo = 1;
                hi_run = 0;
            end
            if (o_sck) hi_run++;
            if (!o_sck && prev) begin
                if (hi_run != exp_div) bad_hi = 1;
                lo_run = 0;
                if (rises < 8) miso_drv = slave[7 - rises];
            end
            if (!o_sck) lo_run++;
            if (o_rv) begin
                vcnt++;
                rise_cyc = cyc;
                if (o_cs !== 1'b1) coinc_bad = 1;
                got_rx = o_rx;
                if (exp_q.size() > 0) exp_v = exp_q.pop_front();
            end
            prev = o_sck;
        end
        check({tag, "_cs_low"}, 32'(cs_low), 32'(exp_cs));
        check({tag, "_pulses"}, 32'(rises), 32'd8);
        check({tag, "_sck_hi"}, 32'(bad_hi), 32'd0);
        check({tag, "_sck_lo"}, 32'(bad_lo), 32'd0);
        check({tag, "_mosi"}, 32'(mseq), 32'(word));
        check({tag, "_valid_cnt"}, 32'(vcnt), 32'd1);
        check({tag, "_valid_cs"}, 32'(coinc_bad), 32'd0);
        check({tag, "_rx"}, 32'(got_rx), 32'(exp_v));
        check({tag, "_rdy_low"}, 32'(ready_bad), 32'd0);
        @(negedge clk);
        check({tag, "_strobe1"}, 32'(o_rv), 32'd0);
    endtask

    initial begin
        int rises;
        int gap;
        bit prev;
        bit seen;
        rst = 1'b1; tx_valid = 1'b0; txd = 8'h00; sel = 0; loop_sel = 1; miso_drv = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(o_cs), 32'd1);
        check("rst_sck", 32'(o_sck), 32'd0);
        check("rst_mosi", 32'(o_mosi), 32'd0);
        check("rst_rx", 32'(o_rx), 32'h00);
        check("rst_rv", 32'(o_rv), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_rdy_in_rst", 32'(o_rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", 32'(o_rdy), 32'd1);

        // Loopback 0xA5
        xfer(8'hA5, 8'h00, 0, 1, 8'h00, 8'hA5, 68, 4, "a5");
        // Slave returns 0x3C while master sends 0xFF
        xfer(8'hFF, 8'h00, 0, 0, 8'h3C, 8'h3C, 68, 4, "slv");

`ifdef SPI_MASTER_BURST_EN
        // Burst: three chained words in one frame
        begin
            int vcnt = 0, sent = 1;
            bit cs_early = 0;
            logic [7:0] e;
            loop_sel = 1; txd = 8'h11; tx_valid = 1'b1;
            wait_ready("burst");
            exp_q.push_back(8'h11);
            @(posedge clk); #1 txd = 8'h22;
            rises = 0; prev = 0;
            for (int n = 0; n < 1500 && vcnt < 3; n++) begin
                @(negedge clk);
                if (o_sck && !prev) rises++;
                prev = o_sck;
                if (o_rv) begin
                    vcnt++;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                    check("burst_rx", 32'(o_rx), 32'(e));
                end
                if (o_cs && !(o_rv && vcnt == 3)) cs_early = 1;
                if (o_rdy && tx_valid) begin
                    exp_q.push_back(txd);
                    sent++;
                    @(posedge clk); #1;
                    if (sent == 2) txd = 8'h33;
                    else           tx_valid = 1'b0;
                end
            end
            check("burst_pulses", 32'(rises), 32'd24);
            check("burst_valid_cnt", 32'(vcnt), 32'd3);
            check("burst_cs_low", 32'(cs_early), 32'd0);
            @(negedge clk);
        end
`else
        // tx_valid held high: 0x01 then 0x80 in separate frames
        xfer(8'h01, 8'h80, 1, 1, 8'h00, 8'h01, 68, 4, "b2b1");
        gap = rise_cyc;
        xfer(8'h80, 8'h00, 0, 1, 8'h00, 8'h80, 68, 4, "b2b2");
        check("b2b_cs_gap", 32'(fall_cyc - gap), 32'd3);
`endif

        // Reset during SCK pulse 4
        loop_sel = 1; txd = 8'hFF; tx_valid = 1'b1;
        wait_ready("mid");
        @(posedge clk); #1 tx_valid = 1'b0;
        rises = 0; prev = 0;
        for (int n = 0; n < 200 && rises < 4; n++) begin
            @(negedge clk);
            if (o_sck && !prev) rises++;
            prev = o_sck;
        end
        check("mid_sck_hi", 32'(o_sck), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_cs", 32'(o_cs), 32'd1);
        check("mid_sck", 32'(o_sck), 32'd0);
        check("mid_mosi", 32'(o_mosi), 32'd0);
        check("mid_rx", 32'(o_rx), 32'h00);
        check("mid_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (o_rv) seen = 1;
        end
        check("mid_no_strobe", 32'(seen), 32'd0);
        xfer(8'h5A, 8'h00, 0, 1, 8'h00, 8'h5A, 68, 4, "post");

        // Fast configuration, loopback 0xC3
        sel = 1;
        @(negedge clk);
        xfer(8'hC3, 8'h00, 0, 1, 8'h00, 8'hC3, 18, 1, "fast");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
